// File: rtl/ram_sdp_clear_if.sv
// Request/response bundle for ram_sdp_clear: write port, read port and status.
interface ram_sdp_clear_if #(
  parameter int addressWidth = 9,
  parameter int wordWidth    = 32,
  parameter int maskWidth    = wordWidth / 8
);
  logic                    wr_en;
  logic [maskWidth-1:0]    wr_mask;
  logic [addressWidth-1:0] wr_addr;
  logic [wordWidth-1:0]    wr_data;
  logic                    rd_en;
  logic [addressWidth-1:0] rd_addr;
  logic [wordWidth-1:0]    rd_data;
  logic                    rd_valid;
  logic                    ready;

  modport master (
    output wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, ready
  );
endinterface

// File: rtl/ram_sdp_clear.sv
// Simple-dual-port RAM with byte-masked writes, post-reset clear sweep and valid-tagged reads.
// Define RAM_SDP_CLEAR_BYPASS_EN for write-first collisions; default is read-first.
module ram_sdp_clear #(
  parameter int                   wordCount    = 512,
  parameter int                   wordWidth    = 32,
  parameter int                   maskWidth    = wordWidth / 8,
  parameter int                   readLatency  = 1,
  parameter logic [wordWidth-1:0] clearValue   = '0,
  parameter int                   addressWidth = $clog2(wordCount)
) (
  input  logic          clk,
  input  logic          reset,
  ram_sdp_clear_if.slave bus
);
  // Stage 1 samples the array; the last stage is the rd_data/rd_valid register.
  localparam int                      STAGES = readLatency + 1;
  localparam logic [addressWidth:0]   WC     = (addressWidth + 1)'(wordCount);
  localparam logic [addressWidth-1:0] LAST   = addressWidth'(wordCount - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [addressWidth-1:0] r_clr_addr;
  logic                    w_ready, w_clr_we;
  logic                    w_wr_in, w_rd_in, w_wr_acc, w_rd_acc;
  logic [wordWidth-1:0]    w_arr, w_rd_word;

  logic [wordWidth-1:0]               r_mem [wordCount];
  logic [STAGES:1]                    r_vld_pipe;
  logic [STAGES-1:1][wordWidth-1:0]   r_dpipe;
  logic [wordWidth-1:0]               r_rd_data;

  always_ff @(posedge clk) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_addr == LAST) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == RUN);
    w_clr_we = (r_state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset)         r_clr_addr <= '0;
    else if (w_clr_we) r_clr_addr <= r_clr_addr + addressWidth'(1);
  end

  // Out-of-range writes are dropped; out-of-range reads return clearValue.
  assign w_wr_in  = {1'b0, bus.wr_addr} < WC;
  assign w_rd_in  = {1'b0, bus.rd_addr} < WC;
  assign w_wr_acc = w_ready & bus.wr_en & w_wr_in;
  assign w_rd_acc = w_ready & bus.rd_en;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_addr] <= clearValue;
    end else if (w_wr_acc) begin
      for (int b = 0; b < maskWidth; b++)
        if (bus.wr_mask[b]) r_mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
    end
  end

  assign w_arr = w_rd_in ? r_mem[bus.rd_addr] : clearValue;

`ifdef RAM_SDP_CLEAR_BYPASS_EN
  // Write-first: merge the enabled write bytes into the sampled word.
  logic w_coll;
  assign w_coll = w_wr_acc & bus.rd_en & (bus.rd_addr == bus.wr_addr);

  always_comb begin
    w_rd_word = w_arr;
    if (w_coll)
      for (int b = 0; b < maskWidth; b++)
        if (bus.wr_mask[b]) w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
  end
`else
  assign w_rd_word = w_arr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_dpipe    <= '0;
      r_rd_data  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_rd_acc};
      r_dpipe[1] <= w_rd_word;
      for (int s = 2; s < STAGES; s++) r_dpipe[s] <= r_dpipe[s-1];
      if (r_vld_pipe[STAGES-1]) r_rd_data <= r_dpipe[STAGES-1];
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_vld_pipe[STAGES];
  assign bus.ready    = w_ready;
endmodule

// File: tb/tb_ram_sdp_clear.sv
// Bench for ram_sdp_clear: latency-1 and latency-2 instances share stimulus, checked against an array model.
module tb_ram_sdp_clear;
  localparam int          WC = 12;
  localparam logic [31:0] CV = 32'hDEADBEEF;
`ifdef RAM_SDP_CLEAR_BYPASS_EN
  localparam logic [31:0] EXP_COLL = 32'hAABBBEEF;
`else
  localparam logic [31:0] EXP_COLL = 32'hDEADBEEF;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_sdp_clear_if #(.addressWidth(4), .wordWidth(32), .maskWidth(4)) b1 ();
  ram_sdp_clear_if #(.addressWidth(4), .wordWidth(32), .maskWidth(4)) b2 ();

  assign b2.wr_en   = b1.wr_en;
  assign b2.wr_mask = b1.wr_mask;
  assign b2.wr_addr = b1.wr_addr;
  assign b2.wr_data = b1.wr_data;
  assign b2.rd_en   = b1.rd_en;
  assign b2.rd_addr = b1.rd_addr;

  ram_sdp_clear #(.wordCount(WC), .wordWidth(32), .maskWidth(4), .readLatency(1),
                  .clearValue(CV), .addressWidth(4))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  ram_sdp_clear #(.wordCount(WC), .wordWidth(32), .maskWidth(4), .readLatency(2),
                  .clearValue(CV), .addressWidth(4))
    dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  typedef struct { int due; logic [31:0] val; } exp_t;

  logic [31:0] mem [WC];
  exp_t        q1[$], q2[$];
  logic [31:0] hold1 = '0, hold2 = '0;
  logic        ev1, ev2;
  int          cnt = 0, edge_no = 0, vcount1 = 0;
  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    logic [31:0] v;
    @(posedge clk);
    edge_no++;
    if (reset) begin
      cnt = 0;
      q1.delete();
      q2.delete();
      hold1 = '0;
      hold2 = '0;
    end else if (cnt < WC) begin
      cnt++;
      if (cnt == WC) foreach (mem[i]) mem[i] = CV;
    end else begin
      if (b1.rd_en) begin
        v = (int'(b1.rd_addr) < WC) ? mem[b1.rd_addr] : CV;
`ifdef RAM_SDP_CLEAR_BYPASS_EN
        if (b1.wr_en && b1.wr_addr == b1.rd_addr && int'(b1.rd_addr) < WC)
          for (int b = 0; b < 4; b++)
            if (b1.wr_mask[b]) v[8*b +: 8] = b1.wr_data[8*b +: 8];
`endif
        q1.push_back('{edge_no + 1, v});
        q2.push_back('{edge_no + 2, v});
      end
      if (b1.wr_en && int'(b1.wr_addr) < WC)
        for (int b = 0; b < 4; b++)
          if (b1.wr_mask[b]) mem[b1.wr_addr][8*b +: 8] = b1.wr_data[8*b +: 8];
    end
    ev1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == edge_no) begin
      ev1 = 1'b1; hold1 = q1[0].val; void'(q1.pop_front());
    end
    ev2 = 1'b0;
    if (q2.size() > 0 && q2[0].due == edge_no) begin
      ev2 = 1'b1; hold2 = q2[0].val; void'(q2.pop_front());
    end
    #1;
    chk("ready_l1", 32'(b1.ready), 32'(cnt >= WC));
    chk("ready_l2", 32'(b2.ready), 32'(cnt >= WC));
    chk("rd_valid_l1", 32'(b1.rd_valid), 32'(ev1));
    chk("rd_valid_l2", 32'(b2.rd_valid), 32'(ev2));
    chk("rd_data_l1", b1.rd_data, hold1);
    chk("rd_data_l2", b2.rd_data, hold2);
    if (b1.rd_valid) vcount1++;
  endtask

  task automatic op(input logic we, input logic [3:0] m, input logic [3:0] wa,
                    input logic [31:0] wd, input logic re, input logic [3:0] ra);
    b1.wr_en = we; b1.wr_mask = m; b1.wr_addr = wa; b1.wr_data = wd;
    b1.rd_en = re; b1.rd_addr = ra;
    tick();
  endtask

  task automatic idle();
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    int n;
    b1.wr_en = 0; b1.wr_mask = 0; b1.wr_addr = 0; b1.wr_data = 0;
    b1.rd_en = 0; b1.rd_addr = 0;

    reset = 1'b1;
    repeat (3) idle();
    chk("reset_ready", 32'(b1.ready), 32'd0);
    chk("reset_rd_data", b2.rd_data, 32'd0);

    reset = 1'b0;
    n = 0;
    while (!b1.ready && n < 50) begin idle(); n++; end
    chk("clear_edges", n, 12);

    vcount1 = 0;
    for (int a = 0; a < WC; a++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    repeat (3) idle();
    chk("sweep_valid_count", vcount1, 12);

    op(1'b1, 4'b0101, 4'd5, 32'h11223344, 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    idle();
    chk("masked_write", b1.rd_data, 32'hDE22BE44);

    op(1'b1, 4'b1100, 4'd3, 32'hAABBCCDD, 1'b1, 4'd3);
    idle();
    chk("collision", b1.rd_data, EXP_COLL);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
    idle();
    chk("collision_after", b1.rd_data, 32'hAABBBEEF);

    for (int a = 0; a < 3; a++) op(1'b1, 4'hF, 4'(a), 32'h10000000 + 32'(a), 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd1);
    chk("lat2_no_early", 32'(b2.rd_valid), 32'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd2);
    chk("lat2_first", b2.rd_data, 32'h10000000);
    idle();
    chk("lat2_second", b2.rd_data, 32'h10000001);
    chk("lat2_no_bubble", 32'(b2.rd_valid), 32'd1);
    idle();
    chk("lat2_third", b2.rd_data, 32'h10000002);
    idle();

    op(1'b1, 4'hF, 4'd15, 32'h0, 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd15);
    idle();
    chk("oor_valid", 32'(b1.rd_valid), 32'd1);
    chk("oor_data", b1.rd_data, CV);
    for (int a = 0; a < WC; a++) op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    repeat (3) idle();

    for (int i = 0; i < 300; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      op(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom),
         ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
    end
    repeat (3) idle();

    op(1'b1, 4'hF, 4'd5, 32'h55555555, 1'b0, 4'd0);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    reset = 1'b1;
    idle();
    chk("rst_mid_ready", 32'(b1.ready), 32'd0);
    chk("rst_mid_data", b2.rd_data, 32'd0);
    reset = 1'b0;
    idle();
    chk("rst_mid_no_valid", 32'(b2.rd_valid), 32'd0);
    n = 1;
    while (!b1.ready && n < 50) begin idle(); n++; end
    chk("reclear_edges", n, 12);
    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
    idle();
    chk("reclear_addr5", b1.rd_data, CV);
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
